// File: rtl/interface_scheduler.sv
// interface_scheduler
//   Shares the single DRAM<->GLB interface unit among four requesters
//   (ifmap load, filter load, bias load, ofmap store). Round-robin
//   arbitration with one transfer in flight: latch the winner's word count
//   and transfer type, pulse start, wait for transfer_done (or the
//   watchdog), then pulse done back to the winner.
//
// Ports
//   core_clk                    core clock
//   reset                       asynchronous reset, active-low
//   req[3:0]                    level requests: 0 ifmap, 1 filter, 2 bias, 3 ofmap store
//   req_words                   word count per requester, slice i belongs to req[i]
//   grant[3:0]                  one-hot owner of the interface unit
//   done[3:0]                   one-cycle completion pulse to the owner
//   start_forward               one-cycle start pulse for requesters 0..2
//   start_backward              one-cycle start pulse for requester 3
//   ifmap_filter_bias_transfer  00 ifmap, 01 filter, 10 bias (00 for store)
//   words_num                   word count of the current transfer
//   transfer_done               completion pulse from the interface unit
//   busy                        high whenever the scheduler is not idle
//   timeout_err                 sticky watchdog error, cleared only by reset
module interface_scheduler #(
  parameter int          ADDR_WIDTH  = 20,
  parameter int          TIMEOUT_W   = 24,
  parameter int unsigned TIMEOUT_MAX = 32'd16777215
) (
  input  logic                    core_clk,
  input  logic                    reset,
  input  logic [3:0]              req,
  input  logic [4*ADDR_WIDTH-1:0] req_words,
  output logic [3:0]              grant,
  output logic [3:0]              done,
  output logic                    start_forward,
  output logic                    start_backward,
  output logic [1:0]              ifmap_filter_bias_transfer,
  output logic [ADDR_WIDTH-1:0]   words_num,
  input  logic                    transfer_done,
  output logic                    busy,
  output logic                    timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_START,
    S_BUSY,
    S_DONE
  } state_t;

  // Last BUSY cycle index before the watchdog fires (counter starts at 0).
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_MAX - 32'd1);

  state_t                  state;
  state_t                  state_nxt;
  logic [1:0]              rr_ptr;
  logic [1:0]              winner;
  logic                    win_vld;
  logic [1:0]              scan_idx;
  logic [ADDR_WIDTH-1:0]   win_words;
  logic [TIMEOUT_W-1:0]    wd_cnt;
  logic                    wd_expire;

  // Round-robin pick: scan from rr_ptr upward; iterating from the far end
  // lets the requester nearest to rr_ptr overwrite the others.
  always_comb begin
    winner   = 2'd0;
    win_vld  = 1'b0;
    scan_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      scan_idx = rr_ptr + 2'(i);
      if (req[scan_idx]) begin
        winner  = scan_idx;
        win_vld = 1'b1;
      end
    end
  end

  assign win_words = req_words[32'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
  assign wd_expire = (TIMEOUT_MAX != 0) && (wd_cnt == WD_LAST);

  always_ff @(posedge core_clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if ((|req) && !timeout_err) state_nxt = S_ARB;
      S_ARB:   state_nxt = win_vld ? S_START : S_IDLE;
      // A zero-length transfer never touches the interface unit.
      S_START: state_nxt = (words_num == '0) ? S_DONE : S_BUSY;
      S_BUSY:  if (transfer_done || wd_expire) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge reset) begin
    if (!reset) begin
      rr_ptr                     <= 2'd0;
      grant                      <= 4'b0000;
      words_num                  <= '0;
      ifmap_filter_bias_transfer <= 2'b00;
      wd_cnt                     <= '0;
      timeout_err                <= 1'b0;
    end else begin
      case (state)
        S_ARB: begin
          if (win_vld) begin
            grant                      <= 4'b0001 << winner;
            words_num                  <= win_words;
            ifmap_filter_bias_transfer <= (winner == 2'd3) ? 2'b00 : winner;
            rr_ptr                     <= winner + 2'd1;
          end
        end
        S_START: wd_cnt <= '0;
        S_BUSY: begin
          // A real completion in the same cycle as expiry wins.
          if (!transfer_done && wd_expire) begin
            timeout_err <= 1'b1;
          end
          wd_cnt <= wd_cnt + TIMEOUT_W'(1);
        end
        S_DONE:  grant <= 4'b0000;
        default: ;
      endcase
    end
  end

  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE) ? grant : 4'b0000;
  assign start_forward  = (state == S_START) && (words_num != '0) && !grant[3];
  assign start_backward = (state == S_START) && (words_num != '0) &&  grant[3];

endmodule
